ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have ports, one per line (name  direction  width  meaning):
 clk  in  1  clock; all state updates on rising edge
 rst  in  1  reset, synchronous, active-high
 ALUControlE  in  5  operation code from ID/EX register
 ALUSrcE, RegDstE, IsShiftE, JalE  in  1 each  operand/destination/shift/link selects
 RD1E, RD2E, ExtImmE, PCPlus8E  in  32 each  register operands, extended immediate, link address
 RegisterRtE, RegisterRdE, ShamtE  in  5 each  destination candidates, shift amount
 ForwardAE, ForwardBE  in  2 each  bypass selects: 00 register, 01 ResultW, 10 ALUOutM, 11 register
 ALUOutM, ResultW  in  32 each  bypass data from MEM and WB
 ALUOutE  out  32  execute result
 WriteDataE  out  32  forwarded RD2 value, for stores
 WriteRegE  out  5  destination register
 StallE  out  1  high while a multiply/divide holds the pipeline

Function
REQ-002 SrcA SHALL be RD1E, ResultW or ALUOutM, chosen by ForwardAE; FwdB SHALL be chosen the same way by ForwardBE.
REQ-003 WriteDataE SHALL equal FwdB.
REQ-004 SrcB SHALL be ExtImmE when ALUSrcE=1, else FwdB.
REQ-005 WriteRegE SHALL be 31 when JalE=1, else RegisterRdE when RegDstE=1, else RegisterRtE.
REQ-006 ALUControlE codes SHALL be:
 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
 6 SLT signed, 7 SLTU
 8 SLL, 9 SRL, 10 SRA
 11 LUI (SrcB<<16)
 16 MULT, 17 MULTU, 18 DIV, 19 DIVU
 20 MFHI, 21 MFLO
 other codes yield 0.
REQ-007 Shifts SHALL operate on FwdB; the amount is ShamtE when IsShiftE=1, else SrcA[4:0].
REQ-008 ADD/SUB SHALL wrap modulo 2^32 with no overflow trap.
REQ-009 When JalE=1, ALUOutE SHALL be PCPlus8E, overriding ALUControlE.
REQ-010 ALUOutE SHALL be 0 for codes 16-19.
REQ-011 A multiply/divide FSM SHALL have the states IDLE, BUSY and DONE.
REQ-012 IDLE with code 16-19 SHALL latch the operands SrcA/FwdB, load counter=0, go to BUSY and assert StallE combinationally in that same cycle.
REQ-013 BUSY SHALL run one shift-add (multiply) or restoring-subtract (divide) step per cycle, increment the counter, hold StallE=1, and move to DONE after the 32nd step.
REQ-014 DONE SHALL write HI/LO at the clock edge, hold StallE=0 so the instruction retires, and return to IDLE.
REQ-015 Each multiply/divide SHALL stall for 33 cycles, 34 cycles total in EX.
REQ-016 MULT/MULTU SHALL produce a 64-bit product, HI=[63:32] and LO=[31:0].
REQ-017 Signed MULT and DIV SHALL work on magnitudes and apply sign correction in DONE.
REQ-018 DIV/DIVU SHALL set LO=quotient, truncated toward zero, and HI=remainder carrying the sign of the dividend.
REQ-019 A divisor of 0 SHALL give HI=dividend and LO=0xFFFFFFFF, with the normal 34-cycle timing.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-021 MFHI/MFLO SHALL return the current HI/LO combinationally; no hazard exists, because the stall serialises them after any preceding multiply/divide.
REQ-022 Operand inputs SHALL be ignored while BUSY; operands come only from the start-cycle latch.

Reset
REQ-023 On rst=1 at a clock edge: FSM to IDLE, counter=0, HI=0, LO=0; StallE SHALL read 0 in the following cycle unless a code 16-19 is present.
REQ-024 rst asserted during BUSY or DONE SHALL abort the operation with no HI/LO update.
REQ-025 The block SHALL have no other state; all other outputs are combinational.

Verification
REQ-026 Bench SHALL cover:
 ADD: RD1E=0x7FFFFFFF, RD2E=1, ALUSrcE=0 -> ALUOutE=0x80000000.
 Forwarding: ForwardAE=10, ALUOutM=5, SUB, RD2E=7 -> ALUOutE=0xFFFFFFFE.
 SRA: IsShiftE=1, ShamtE=4, RD2E=0x80000000 -> ALUOutE=0xF8000000.
 MULT: -3 x 7 -> StallE high for exactly 33 cycles; then MFLO=0xFFFFFFEB, MFHI=0xFFFFFFFF.
 DIV: -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divide by zero -> LO=0xFFFFFFFF, HI=dividend.
 Reset at step 10 of DIVU -> StallE drops, HI=LO=0, and the next MULTU completes normally.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipeline.
//
// Selects forwarded operands, computes the ALU result and the destination
// register, and runs a 32-step sequential multiply/divide unit that holds
// the pipeline through StallE while it works. HI/LO are written when the
// operation reaches DONE.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ALUControlE               operation code
//   ALUSrcE, RegDstE,
//   IsShiftE, JalE            operand/destination/shift-amount/link selects
//   RD1E, RD2E, ExtImmE,
//   PCPlus8E                  register operands, immediate, link address
//   RegisterRtE, RegisterRdE,
//   ShamtE                    destination candidates, shift amount
//   ForwardAE, ForwardBE      bypass selects (00/11 reg, 01 ResultW, 10 ALUOutM)
//   ALUOutM, ResultW          bypass data
//   ALUOutE                   execute result
//   WriteDataE                forwarded RD2 value (store data)
//   WriteRegE                 destination register
//   StallE                    high while a multiply/divide holds the pipeline
//
// Multiply/divide FSM:
//   state | meaning
//   IDLE  | no operation; a code 16-19 latches operands and stalls
//   BUSY  | one shift-add or restoring-subtract step per cycle, 32 steps
//   DONE  | sign correction, HI/LO written at the edge, instruction retires

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ALUControlE,
    input  logic        ALUSrcE,
    input  logic        RegDstE,
    input  logic        IsShiftE,
    input  logic        JalE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] ExtImmE,
    input  logic [31:0] PCPlus8E,
    input  logic [4:0]  RegisterRtE,
    input  logic [4:0]  RegisterRdE,
    input  logic [4:0]  ShamtE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] ResultW,
    output logic [31:0] ALUOutE,
    output logic [31:0] WriteDataE,
    output logic [4:0]  WriteRegE,
    output logic        StallE
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t   state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] op_a_q, op_b_q;
    logic        div_q, sgn_q;
    logic [31:0] acc_hi_q, acc_lo_q;
    logic [31:0] hi_q, lo_q;

    logic [31:0] src_a, fwd_b, src_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;

    // ---------------- operand selection ----------------
    always_comb begin
        src_a = RD1E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUOutM;
            default: src_a = RD1E;
        endcase
        fwd_b = RD2E;
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUOutM;
            default: fwd_b = RD2E;
        endcase
    end

    assign src_b      = ALUSrcE ? ExtImmE : fwd_b;
    assign WriteDataE = fwd_b;
    assign shamt      = IsShiftE ? ShamtE : src_a[4:0];
    assign WriteRegE  = JalE ? 5'd31 : (RegDstE ? RegisterRdE : RegisterRtE);

    // ---------------- ALU ----------------
    always_comb begin
        alu_res = 32'd0;
        case (ALUControlE)
            5'd0:  alu_res = src_a + src_b;
            5'd1:  alu_res = src_a - src_b;
            5'd2:  alu_res = src_a & src_b;
            5'd3:  alu_res = src_a | src_b;
            5'd4:  alu_res = src_a ^ src_b;
            5'd5:  alu_res = ~(src_a | src_b);
            5'd6:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            5'd7:  alu_res = {31'd0, src_a < src_b};
            5'd8:  alu_res = fwd_b << shamt;
            5'd9:  alu_res = fwd_b >> shamt;
            5'd10: alu_res = $signed(fwd_b) >>> shamt;
            5'd11: alu_res = {src_b[15:0], 16'd0};
            5'd20: alu_res = hi_q;
            5'd21: alu_res = lo_q;
            default: alu_res = 32'd0;
        endcase
    end

    assign ALUOutE = JalE ? PCPlus8E : alu_res;

    // ---------------- multiply/divide ----------------
    logic        is_md, st_div, st_sgn;
    logic [31:0] st_abs_a, st_abs_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] add33, shl33;
    logic        ge;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod, prod_fix;
    logic [31:0] res_hi, res_lo;

    assign is_md  = (ALUControlE[4:2] == 3'b100);
    assign st_div = ALUControlE[1];
    assign st_sgn = ~ALUControlE[0];

    assign st_abs_a = (st_sgn && src_a[31]) ? -src_a : src_a;
    assign st_abs_b = (st_sgn && fwd_b[31]) ? -fwd_b : fwd_b;
    assign abs_a    = (sgn_q && op_a_q[31]) ? -op_a_q : op_a_q;
    assign abs_b    = (sgn_q && op_b_q[31]) ? -op_b_q : op_b_q;

    // Multiply: acc_lo holds the multiplier, the product shifts in from the top.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and
    // quotient bits in.
    always_comb begin
        add33 = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, abs_a} : 33'd0);
        shl33 = {acc_hi_q, acc_lo_q[31]};
        ge    = (shl33 >= {1'b0, abs_b});
        if (div_q) begin
            step_hi = ge ? 32'(shl33 - {1'b0, abs_b}) : shl33[31:0];
            step_lo = {acc_lo_q[30:0], ge};
        end else begin
            step_hi = add33[32:1];
            step_lo = {add33[0], acc_lo_q[31:1]};
        end
    end

    // Sign correction applied to the magnitude result when leaving DONE.
    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = (sgn_q && (op_a_q[31] ^ op_b_q[31])) ? -prod : prod;
        if (!div_q) begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end else if (op_b_q == 32'd0) begin
            res_hi = op_a_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_lo = (sgn_q && (op_a_q[31] ^ op_b_q[31])) ? -acc_lo_q : acc_lo_q;
            res_hi = (sgn_q && op_a_q[31]) ? -acc_hi_q : acc_hi_q;
        end
    end

    always_comb begin
        state_d = state_q;
        StallE  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_md) begin
                    StallE  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                StallE = 1'b1;
                if (cnt_q == 6'd31)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            div_q    <= 1'b0;
            sgn_q    <= 1'b0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (is_md) begin
                        op_a_q   <= src_a;
                        op_b_q   <= fwd_b;
                        div_q    <= st_div;
                        sgn_q    <= st_sgn;
                        cnt_q    <= 6'd0;
                        acc_hi_q <= 32'd0;
                        acc_lo_q <= st_div ? st_abs_a : st_abs_b;
                    end
                end
                BUSY: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + 6'd1;
                end
                DONE: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule
